// File: rtl/prog_mem_controller_if.sv
// Bus bundle between the instruction fetchers, the program-memory controller and the
// external program memory. The controller uses the slave view; fetchers and memory model use the master view.
interface prog_mem_controller_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CHANNELS-1:0]            mem_read_valid;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]            mem_read_ready;
    logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;

    modport slave (
        input  consumer_read_valid,
        input  consumer_read_address,
        output consumer_read_ready,
        output consumer_read_data,
        output mem_read_valid,
        output mem_read_address,
        input  mem_read_ready,
        input  mem_read_data
    );

    modport master (
        output consumer_read_valid,
        output consumer_read_address,
        input  consumer_read_ready,
        input  consumer_read_data,
        input  mem_read_valid,
        input  mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/prog_mem_controller.sv
// Read-only program-memory controller: fixed-priority arbitration of fetcher requests onto
// memory read channels, each channel an IDLE/WAITING/RELAYING FSM relaying one word back.
module prog_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    prog_mem_controller_if.slave   bus
);
    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAITING  = 2'd1,
        RELAYING = 2'd2
    } state_t;

    state_t                             state_r  [NUM_CHANNELS];
    logic [IDX_BITS-1:0]                served_r [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]           busy_r;
    logic [NUM_CHANNELS-1:0]            mem_valid_r;
    logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_addr_r;
    logic [NUM_CONSUMERS-1:0]           cons_ready_r;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] cons_data_r;

    logic [NUM_CHANNELS-1:0]            grant_valid_s;
    logic [IDX_BITS-1:0]                grant_idx_s [NUM_CHANNELS];

    // Returns {found, index} of the lowest set bit of req.
    function automatic logic [IDX_BITS:0] lowest_set(input logic [NUM_CONSUMERS-1:0] req);
        logic [IDX_BITS:0] res;
        res = {(IDX_BITS+1){1'b0}};
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                res = {1'b1, IDX_BITS'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign bus.mem_read_valid      = mem_valid_r;
    assign bus.mem_read_address    = mem_addr_r;
    assign bus.consumer_read_ready = cons_ready_r;
    assign bus.consumer_read_data  = cons_data_r;

    // Grant selection: channels in ascending order, each excluding consumers already taken this cycle.
    always_comb begin : grant_logic
        logic [NUM_CONSUMERS-1:0] taken_s;
        logic [IDX_BITS:0]        pick_s;
        taken_s       = busy_r;
        pick_s        = {(IDX_BITS+1){1'b0}};
        grant_valid_s = {NUM_CHANNELS{1'b0}};
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            pick_s             = lowest_set(bus.consumer_read_valid & ~taken_s);
            grant_valid_s[ch]  = (state_r[ch] == IDLE) && pick_s[IDX_BITS];
            grant_idx_s[ch]    = pick_s[IDX_BITS-1:0];
            taken_s            = taken_s | (grant_valid_s[ch] ?
                                 (NUM_CONSUMERS'(1'b1) << pick_s[IDX_BITS-1:0]) :
                                 {NUM_CONSUMERS{1'b0}});
        end
    end

    // Per-channel FSMs together with the busy flags and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_r[ch]  <= IDLE;
                served_r[ch] <= {IDX_BITS{1'b0}};
            end
            busy_r       <= {NUM_CONSUMERS{1'b0}};
            mem_valid_r  <= {NUM_CHANNELS{1'b0}};
            mem_addr_r   <= {(NUM_CHANNELS*ADDR_BITS){1'b0}};
            cons_ready_r <= {NUM_CONSUMERS{1'b0}};
            cons_data_r  <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state_r[ch])
                    IDLE: begin
                        if (grant_valid_s[ch]) begin
                            served_r[ch]             <= grant_idx_s[ch];
                            busy_r[grant_idx_s[ch]]  <= 1'b1;
                            mem_addr_r[ch*ADDR_BITS +: ADDR_BITS] <=
                                bus.consumer_read_address[grant_idx_s[ch]*ADDR_BITS +: ADDR_BITS];
                            mem_valid_r[ch]          <= 1'b1;
                            state_r[ch]              <= WAITING;
                        end else begin
                            state_r[ch] <= IDLE;
                        end
                    end
                    WAITING: begin
                        if (bus.mem_read_ready[ch]) begin
                            mem_valid_r[ch] <= 1'b0;
                            cons_data_r[served_r[ch]*DATA_BITS +: DATA_BITS] <=
                                bus.mem_read_data[ch*DATA_BITS +: DATA_BITS];
                            cons_ready_r[served_r[ch]] <= 1'b1;
                            state_r[ch]     <= RELAYING;
                        end else begin
                            state_r[ch] <= WAITING;
                        end
                    end
                    RELAYING: begin
                        // The fetcher withdrawing its request is the acknowledgement of the word.
                        if (!bus.consumer_read_valid[served_r[ch]]) begin
                            cons_ready_r[served_r[ch]] <= 1'b0;
                            busy_r[served_r[ch]]       <= 1'b0;
                            state_r[ch]                <= IDLE;
                        end else begin
                            state_r[ch] <= RELAYING;
                        end
                    end
                    default: begin
                        state_r[ch] <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/prog_mem_controller.md
# prog_mem_controller

Read-only program-memory controller between the per-core instruction fetchers and the external program memory. It arbitrates up to NUM_CONSUMERS fetcher read requests onto NUM_CHANNELS memory read channels and relays each returned instruction word to the fetcher that requested it. Its consumer-side handshake is the same valid/ready pair the fetcher drives and samples.

## Interface
Parameters:
- ADDR_BITS, 8: program memory address width.
- DATA_BITS, 16: instruction word width.
- NUM_CONSUMERS, 4: number of fetchers served.
- NUM_CHANNELS, 1: number of concurrent memory read channels; must be ≤ NUM_CONSUMERS.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- consumer_read_valid  in  NUM_CONSUMERS  per-fetcher request.
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed request addresses; consumer i is at bits [i*ADDR_BITS +: ADDR_BITS].
- consumer_read_ready  out  NUM_CONSUMERS  per-fetcher response strobe.
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed instruction words, packed the same way.
- mem_read_valid  out  NUM_CHANNELS  per-channel memory request.
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  per-channel request address.
- mem_read_ready  in  NUM_CHANNELS  per-channel memory response strobe.
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  per-channel returned word.

## Operation
- Each channel has its own FSM with states IDLE, WAITING and RELAYING, a served-consumer index register and a data path.
- A busy bit per consumer marks that the consumer is currently owned by some channel.
- **IDLE:** the channel grants the lowest-index consumer i that has consumer_read_valid[i]=1 and busy[i]=0.
  - On grant: set busy[i], latch the address onto mem_read_address, set mem_read_valid=1, go to WAITING.
  - Channels are evaluated in ascending index order within one cycle. A consumer granted by a lower channel is not eligible for a higher channel in the same cycle, so two channels never take the same consumer.
- **WAITING:** hold mem_read_valid and the address until mem_read_ready=1. Then:
  - mem_read_valid←0;
  - consumer_read_data[i]←mem_read_data of this channel;
  - consumer_read_ready[i]←1;
  - go to RELAYING.
- **RELAYING:** hold consumer_read_ready[i] and the data while consumer_read_valid[i]=1. When consumer_read_valid[i]=0: consumer_read_ready[i]←0, clear busy[i], go to IDLE.
- Arbitration is fixed priority (lowest index wins). Starvation is bounded because a fetcher issues only one request per instruction.

## Timing
- **Reset:** all FSMs go to IDLE. mem_read_valid, mem_read_address, consumer_read_ready, consumer_read_data and busy all reset to 0. Reset is taken on any edge, including mid-transaction. Any memory response arriving after reset is ignored because the channel is IDLE.
- **Request latency:** consumer_read_valid high at edge k gives mem_read_valid high after edge k (one registered stage).
- **Response latency:** mem_read_ready high at edge m gives consumer_read_ready and data after edge m. mem_read_valid is low after edge m.
- **Release:** consumer_read_valid low at edge r gives consumer_read_ready low after edge r. The channel can grant again at edge r+1.
- With a zero-wait memory (ready sampled the edge after valid rises), the minimum round trip is request to ready in 2 edges.
- mem_read_ready while IDLE or RELAYING is ignored. mem_read_data is sampled only in WAITING with ready=1.
- The address is latched at grant. Later changes to consumer_read_address do not affect the outstanding request.
- If a consumer drops valid during WAITING, the request still completes. The data is relayed and ready is asserted for one cycle, then cleared because valid is low.
- Requests beyond the free channels wait with no loss. They are granted in index order as channels return to IDLE.
- consumer_read_data[i] holds its last value after ready drops, until that consumer's next response.

## Test plan
1. **Reset with requests pending.**
   - Stimulus: reset with all consumer valid=1.
   - Required: every output is 0 and stays 0 while reset=1.
2. **Single fetch, 1 channel.**
   - Stimulus: consumer 0 requests address 0x10. Memory returns 0xABCD with zero wait. The consumer drops valid the cycle after it sees ready.
   - Required: mem address 0x10, consumer_read_data[0]=0xABCD, ready high for exactly 1 cycle, channel IDLE again.
3. **Contention, 1 channel.**
   - Stimulus: consumers 0–3 request 0x00–0x03 in the same cycle. Memory returns 0xDEAD, 0xBEEF, 0xCAFE, 0x1234 with a 3-cycle delay each.
   - Required: service order 0, 1, 2, 3, and each consumer receives its own word.
4. **Two channels.**
   - Stimulus: NUM_CHANNELS=2; consumers 1 and 3 request 0x20 and 0x7F together.
   - Required: channel 0 serves consumer 1 and channel 1 serves consumer 3 in the same cycle. Channel 1 responds first, with 0x8888. Both consumers get the correct data, and there is no duplicate grant.
5. **Delayed release.**
   - Stimulus: the consumer holds valid for 5 cycles after receiving 0x5678.
   - Required: ready and data held for 5 cycles, and no new grant to that consumer until valid drops.
6. **Reset mid-operation.**
   - Stimulus: reset asserted in WAITING; memory ready arrives 1 cycle after reset is released.
   - Required: the response is ignored and no consumer ready is asserted. A following request to 0xFF returning 0x9999 completes normally.
